inst_prefetch: RTL and testbench
================================

# inst_prefetch

Instruction prefetch unit between the PC-redirect logic and the IF/ID pipeline register. It replaces the combinational IMEM read with a valid/ready request port that tolerates variable latency, and keeps up to DEPTH fetches in flight. Fetched words go into a small in-order buffer that feeds IF/ID. Branch and trap redirects flush the buffer and discard any stale in-flight responses.

## Interface
Parameters:
- DEPTH, 4: buffer entries and maximum outstanding requests; power of two, ≥2.
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. Asynchronous, active-low.
- i_redirect  in  1  redirect request; the trap/branch select is already resolved upstream.
- i_redirect_addr  in  XLEN  new fetch address.
- o_req_valid  out  1  IMEM request valid.
- o_req_addr  out  XLEN  IMEM request address.
- i_req_ready  in  1  IMEM accepts the request.
- i_rsp_valid  in  1  IMEM response valid; responses return in order.
- i_rsp_inst  in  INST_WIDTH  fetched word.
- i_rsp_err  in  1  bus error on this response.
- o_valid  out  1  head entry valid for IF/ID.
- i_ready  in  1  IF/ID consumes the head entry (equal to !ifid_stall).
- o_pc  out  XLEN  PC of the head entry.
- o_pc_4  out  XLEN  o_pc + 4.
- o_inst  out  INST_WIDTH  instruction of the head entry; 32'h0000_0013 (NOP) when the entry is flagged.
- o_t_inst_addr_misaligned  out  1  head entry carries a misaligned-fetch trap.
- o_t_inst_access_fault  out  1  head entry carries an access-fault trap.

## Operation
- State:
  - fetch_pc
  - buffer (fetch_fifo)
  - outstanding counter `os`: requests issued and not yet answered, including ones marked for discard.
  - discard counter `drop`.
  - halted flag.
- Credit rule: o_req_valid = !halted && !i_redirect && fetch_pc[1:0]==0 && (occupancy + os) < DEPTH.
  - A response can therefore never find the buffer full.
- o_req_addr = fetch_pc. On acceptance (o_req_valid && i_req_ready): fetch_pc += 4 (wraps modulo 2^XLEN) and os += 1.
- Response (i_rsp_valid):
  - os -= 1.
  - If drop > 0: drop -= 1 and the response is discarded.
  - Otherwise push {pc, inst, err}. The pc comes from a shadow response-PC register that advances by 4 on each kept response.
  - If i_rsp_err: the entry is flagged as an access fault and halted is set. Later responses are still counted but are discarded (drop ← os − 1).
- Misaligned fetch: fetch_pc[1:0] != 0 with !halted and buffer not full pushes one entry flagged as misaligned (pc = fetch_pc) with no bus request, then sets halted.
- Redirect (i_redirect):
  - buffer cleared; fetch_pc and response-PC ← i_redirect_addr; halted ← 0.
  - drop ← os − (i_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is discarded.
- Pop on o_valid && i_ready.
- o_valid = !empty && !i_redirect.
- Simultaneous push and pop on a full buffer is legal.
- Flag priority at the head entry: misaligned over fault. Only one flag is ever set per entry.

## Timing
- Reset values:
  - o_req_valid 0 during reset; fetch_pc RESET_VECTOR; os, drop, halted 0; buffer empty.
  - o_valid 0; o_pc RESET_VECTOR; o_inst NOP; both trap flags 0.
- First request is asserted in the first cycle after reset is released.
- Latency: a response in cycle N gives o_valid in cycle N+1. There is no bypass path.
- Redirect in cycle N: no request is issued in cycle N; the first request to the new address is issued in cycle N+1.
- Reset asserted mid-operation clears all state asynchronously. Responses from IMEM after reset release are the IMEM's responsibility; IMEM is reset by the same i_rst_n.
- o_req_addr and o_req_valid must be held stable while i_req_ready is low, unless i_redirect is asserted.

## Structure
- cotm32_pkg gets:
  - fetch_entry_t {pc[XLEN], inst[INST_WIDTH], misaligned, fault}
  - INST_NOP constant
  - PREFETCH_DEPTH default
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop and flush, occupancy output, async active-low reset; pointers of width $clog2(DEPTH)+1.
- Top level holds fetch_pc, os, drop, halted and the output muxing.

## Test plan
- Reset release with i_req_ready=1 and 1-cycle response latency, i_ready=1 → requests to 0x0, 0x4, 0x8 …; o_valid from cycle 2; o_pc sequence 0x0, 0x4, 0x8 with matching o_inst.
- i_ready=0 held → exactly DEPTH (4) requests are issued and then o_req_valid drops. Releasing i_ready gives all 4 entries in order, then fetching resumes at 0x10.
- 3 requests outstanding, redirect to 0x100 → the next 3 responses are discarded, the next entry has o_pc=0x100, and no stale PC ever appears on the output.
- Redirect to 0x102 → no bus request; one entry with o_pc=0x102, o_t_inst_addr_misaligned=1, o_inst=NOP; o_req_valid stays 0 until the next redirect.
- i_rsp_err on the fetch of 0x8 → entry 0x8 has o_t_inst_access_fault=1; the remaining in-flight responses are dropped; fetching stops until a redirect, and after redirecting to 0x200 the first entry has o_pc=0x200.
- Redirect and response in the same cycle, with a random i_req_ready and latency of 1–5 cycles over 10k cycles → the output PC stream exactly matches the reference sequence model.

Source files
------------

// File: rtl/cotm32_pkg.sv
// rtl/cotm32_pkg.sv - shared types and constants for the cotm32 fetch path
// Provides XLEN/INST_WIDTH, the NOP encoding, the default prefetch depth
// and the fetch_entry_t record carried from IMEM to IF/ID.
package cotm32_pkg;

    localparam int XLEN           = 32;
    localparam int INST_WIDTH     = 32;
    localparam int PREFETCH_DEPTH = 4;

    localparam logic [INST_WIDTH-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INST_WIDTH-1:0] inst;
        logic                  misaligned;
        logic                  fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order buffer of fetch entries with flush
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             drop all entries (wins over push/pop)
//   push, push_data   write one entry; accepted when not full or popping
//   pop               remove head entry; ignored when empty
//   head              current head entry (RESET_ENTRY after reset)
//   empty, full       occupancy flags
//   count             number of stored entries
module fetch_fifo
    import cotm32_pkg::*;
#(
    parameter int           DEPTH       = PREFETCH_DEPTH,
    parameter fetch_entry_t RESET_ENTRY = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_ENTRY;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - instruction prefetch unit between PC redirect and IF/ID
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_redirect, i_redirect_addr branch/trap redirect and its target
//   o_req_valid, o_req_addr,
//   i_req_ready                 IMEM request handshake
//   i_rsp_valid, i_rsp_inst,
//   i_rsp_err                   in-order IMEM responses
//   o_valid, i_ready            head entry handshake towards IF/ID
//   o_pc, o_pc_4, o_inst        head entry PC, PC+4 and instruction (NOP if trapped)
//   o_t_inst_addr_misaligned,
//   o_t_inst_access_fault       head entry trap flags
module inst_prefetch
    import cotm32_pkg::*;
#(
    parameter int              DEPTH        = PREFETCH_DEPTH,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_redirect,
    input  logic [XLEN-1:0]       i_redirect_addr,
    output logic                  o_req_valid,
    output logic [XLEN-1:0]       o_req_addr,
    input  logic                  i_req_ready,
    input  logic                  i_rsp_valid,
    input  logic [INST_WIDTH-1:0] i_rsp_inst,
    input  logic                  i_rsp_err,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [XLEN-1:0]       o_pc,
    output logic [XLEN-1:0]       o_pc_4,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_t_inst_addr_misaligned,
    output logic                  o_t_inst_access_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam fetch_entry_t RESET_ENTRY = '{
        pc:         RESET_VECTOR,
        inst:       INST_NOP,
        misaligned: 1'b0,
        fault:      1'b0
    };

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   os;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   os_next;
    logic [CW-1:0]   drop_next;
    logic            halted;
    logic            req_pend;

    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CW-1:0]   fifo_count;
    logic            push;
    logic            pop;

    logic            aligned;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_keep;
    logic            mis_push;

    assign aligned   = (fetch_pc[1:0] == 2'b00);
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, os}) < (CW + 1)'(DEPTH);

    // req_pend keeps a stalled request asserted even if a fault halts
    // fetching meanwhile; the handshake must not be withdrawn.
    assign o_req_valid = i_rst_n && !i_redirect && aligned
                         && (req_pend || (!halted && credit_ok));
    assign o_req_addr  = fetch_pc;
    assign req_fire    = o_req_valid && i_req_ready;

    assign rsp_keep = i_rsp_valid && (drop == '0) && !i_redirect;
    assign pop      = o_valid && i_ready;
    assign mis_push = !halted && !aligned && !i_redirect && !rsp_keep
                      && (!fifo_full || pop);
    assign push     = rsp_keep || mis_push;

    always_comb begin
        push_data = '{pc: fetch_pc, inst: INST_NOP, misaligned: 1'b1, fault: 1'b0};
        if (rsp_keep) begin
            push_data = '{pc: rsp_pc, inst: i_rsp_inst, misaligned: 1'b0, fault: i_rsp_err};
        end
    end

    assign os_next = os + CW'(req_fire) - CW'(i_rsp_valid);

    // drop counts responses still owed by IMEM that belong to a dead stream.
    always_comb begin
        drop_next = drop;
        if (i_redirect) begin
            drop_next = os - CW'(i_rsp_valid);
        end else begin
            if (i_rsp_valid && (drop != '0)) begin
                drop_next = drop - CW'(1);
            end
            if (rsp_keep && i_rsp_err) begin
                // Everything still in flight after this cycle is stale.
                drop_next = os_next;
            end else if (req_fire && halted) begin
                // A request held over a halt is stale on arrival.
                drop_next = drop_next + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc <= RESET_VECTOR;
            rsp_pc   <= RESET_VECTOR;
            os       <= '0;
            drop     <= '0;
            halted   <= 1'b0;
            req_pend <= 1'b0;
        end else begin
            os   <= os_next;
            drop <= drop_next;
            if (i_redirect) begin
                fetch_pc <= i_redirect_addr;
                rsp_pc   <= i_redirect_addr;
                halted   <= 1'b0;
                req_pend <= 1'b0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if ((rsp_keep && i_rsp_err) || mis_push) begin
                    halted <= 1'b1;
                end
                req_pend <= o_req_valid && !i_req_ready;
            end
        end
    end

    fetch_fifo #(
        .DEPTH       (DEPTH),
        .RESET_ENTRY (RESET_ENTRY)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign o_valid                  = !fifo_empty && !i_redirect;
    assign o_pc                     = head.pc;
    assign o_pc_4                   = head.pc + 32'd4;
    assign o_inst                   = (head.misaligned || head.fault) ? INST_NOP : head.inst;
    assign o_t_inst_addr_misaligned = head.misaligned;
    assign o_t_inst_access_fault    = head.fault && !head.misaligned;

endmodule

// File: tb/tb_inst_prefetch.sv
// tb/tb_inst_prefetch.sv - scoreboard bench for inst_prefetch
module tb_inst_prefetch;
    import cotm32_pkg::*;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_addr = '0;
    logic        o_req_valid;
    logic [31:0] o_req_addr;
    logic        i_req_ready = 1'b0;
    logic        i_rsp_valid = 1'b0;
    logic [31:0] i_rsp_inst = '0;
    logic        i_rsp_err = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] o_pc_4;
    logic [31:0] o_inst;
    logic        o_t_inst_addr_misaligned;
    logic        o_t_inst_access_fault;

    inst_prefetch #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
        .i_clk                    (i_clk),
        .i_rst_n                  (i_rst_n),
        .i_redirect               (i_redirect),
        .i_redirect_addr          (i_redirect_addr),
        .o_req_valid              (o_req_valid),
        .o_req_addr               (o_req_addr),
        .i_req_ready              (i_req_ready),
        .i_rsp_valid              (i_rsp_valid),
        .i_rsp_inst               (i_rsp_inst),
        .i_rsp_err                (i_rsp_err),
        .o_valid                  (o_valid),
        .i_ready                  (i_ready),
        .o_pc                     (o_pc),
        .o_pc_4                   (o_pc_4),
        .o_inst                   (o_inst),
        .o_t_inst_addr_misaligned (o_t_inst_addr_misaligned),
        .o_t_inst_access_fault    (o_t_inst_access_fault)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } imem_req_t;

    imem_req_t    imem_q[$];
    fetch_entry_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int          lat_min = 1, lat_max = 1;
    int          rr_rand = 0, ready_mode = 1, redir_rand = 0, err_rand = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    logic [31:0] model_pc, req_model_pc, prev_addr, force_addr;
    bit          model_halted, prev_stall, force_redirect;
    int          cyc, first_valid, n_req, n_reqv, n_pop, n_fault_pop;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h00C0_FFEE;
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return (a == err_addr) || (err_rand != 0 && a[9:2] == 8'h5A);
    endfunction

    task automatic model_redirect(input logic [31:0] a);
        exp_q.delete();
        model_pc     = a;
        req_model_pc = a;
        model_halted = 1'b0;
        if (a[1:0] != 2'b00) begin
            exp_q.push_back('{pc: a, inst: INST_NOP, misaligned: 1'b1, fault: 1'b0});
            model_halted = 1'b1;
        end
    endtask

    task automatic model_refill();
        fetch_entry_t e;
        while (exp_q.size() < DEPTH && !model_halted) begin
            e.pc         = model_pc;
            e.fault      = is_err(model_pc);
            e.misaligned = 1'b0;
            e.inst       = e.fault ? INST_NOP : inst_of(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
            if (e.fault) model_halted = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n     = 1'b0;
        i_redirect  = 1'b0;
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b0;
        i_rsp_err   = 1'b0;
        i_ready     = 1'b0;
        imem_q.delete();
        prev_stall     = 1'b0;
        force_redirect = 1'b0;
        #1;
        check("rst_req_valid", o_req_valid, 0);
        check("rst_valid", o_valid, 0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_inst", o_inst, INST_NOP);
        check("rst_mis", o_t_inst_addr_misaligned, 0);
        check("rst_fault", o_t_inst_access_fault, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_redirect(32'h0);
        model_refill();
        cyc = 0; first_valid = -1;
        n_req = 0; n_reqv = 0; n_pop = 0; n_fault_pop = 0;
    endtask

    task automatic cycle();
        imem_req_t    r;
        fetch_entry_t e;
        logic [31:0]  a;
        i_redirect = 1'b0;
        if (force_redirect) begin
            i_redirect      = 1'b1;
            i_redirect_addr = force_addr;
            force_redirect  = 1'b0;
        end else if (redir_rand != 0 && $urandom_range(0, 99) < 3) begin
            a = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            i_redirect      = 1'b1;
            i_redirect_addr = a;
        end
        i_req_ready = (rr_rand != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        i_ready     = (ready_mode == 2) ? ($urandom_range(0, 2) != 0) : (ready_mode != 0);
        i_rsp_valid = 1'b0;
        i_rsp_err   = 1'b0;
        i_rsp_inst  = '0;
        if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
            r = imem_q.pop_front();
            i_rsp_valid = 1'b1;
            i_rsp_err   = is_err(r.addr);
            i_rsp_inst  = inst_of(r.addr);
        end
        #1;
        if (i_redirect) check("req_in_redirect", o_req_valid, 0);
        if (prev_stall && !i_redirect) begin
            check("req_hold_valid", o_req_valid, 1);
            check("req_hold_addr", o_req_addr, prev_addr);
        end
        if (o_req_valid) n_reqv++;
        if (o_req_valid && i_req_ready) begin
            check("req_addr", o_req_addr, req_model_pc);
            req_model_pc = req_model_pc + 32'd4;
            r.addr = o_req_addr;
            r.due  = cyc + $urandom_range(lat_min, lat_max);
            imem_q.push_back(r);
            n_req++;
        end
        prev_stall = o_req_valid && !i_req_ready && !i_redirect;
        prev_addr  = o_req_addr;
        if (o_valid && first_valid < 0) first_valid = cyc;
        if (o_valid && i_ready) begin
            n_pop++;
            if (o_t_inst_access_fault) n_fault_pop++;
            if (exp_q.size() == 0) begin
                check("unexpected_entry", o_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", o_pc, e.pc);
                check("pop_pc4", o_pc_4, e.pc + 32'd4);
                check("pop_inst", o_inst, e.inst);
                check("pop_mis", o_t_inst_addr_misaligned, e.misaligned);
                check("pop_fault", o_t_inst_access_fault, e.fault);
            end
        end
        if (i_redirect) model_redirect(i_redirect_addr);
        model_refill();
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int guard;

        // Straight-line fetch, 1-cycle IMEM, no stalls.
        do_reset();
        run(20);
        check("first_valid_cycle", first_valid, 2);
        check("basic_pops", n_pop >= 12, 1);

        // Consumer stalled: credit limits to DEPTH requests.
        do_reset();
        ready_mode = 0;
        run(12);
        check("credit_reqs", n_req, DEPTH);
        check("credit_stall", o_req_valid, 0);
        ready_mode = 1;
        n_pop = 0;
        run(20);
        check("drain_pops", n_pop >= 8, 1);

        // Redirect with three in flight.
        do_reset();
        lat_min = 5; lat_max = 5;
        guard = 0;
        while (imem_q.size() != 3 && guard < 20) begin
            cycle();
            guard++;
        end
        check("three_in_flight", imem_q.size(), 3);
        force_redirect = 1'b1; force_addr = 32'h100;
        n_pop = 0;
        run(30);
        check("post_redirect_pops", n_pop > 0, 1);

        // Misaligned target halts fetching.
        force_redirect = 1'b1; force_addr = 32'h102;
        run(1);
        n_reqv = 0; n_pop = 0;
        run(20);
        check("mis_no_requests", n_reqv, 0);
        check("mis_single_entry", n_pop, 1);
        force_redirect = 1'b1; force_addr = 32'h200;
        run(20);

        // Bus error on 0x8.
        lat_min = 2; lat_max = 2;
        err_addr = 32'h8;
        do_reset();
        run(15);
        n_reqv = 0;
        run(15);
        check("fault_no_requests", n_reqv, 0);
        check("fault_entry_seen", n_fault_pop, 1);
        err_addr = 32'hFFFF_FFFF;
        force_redirect = 1'b1; force_addr = 32'h200;
        n_pop = 0;
        run(20);
        check("fault_recover_pops", n_pop > 0, 1);

        // Random stress.
        do_reset();
        lat_min = 1; lat_max = 5;
        rr_rand = 1; ready_mode = 2; redir_rand = 1; err_rand = 1;
        run(10000);
        check("random_progress", n_pop > 1000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
